// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit: FSM state
// encoding, RV32I major opcodes, and the ALU / PC-source select encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_RFN = 2'b10,
        ALU_IFN = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_RS1   = 2'b10
    } pc_src_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic is_known_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Memory acknowledge watchdog. Counts consecutive cycles in which a request
// is outstanding without an ack. 'expired' flags the cycle that would be the
// ACK_TIMEOUT-th such cycle; an ack in that same cycle takes priority because
// 'en' is already low when mem_ack is high. ACK_TIMEOUT = 0 disables it.
module ack_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    logic [TW-1:0] cnt;

    // Wait-cycle counter; restarts whenever the request is satisfied or idle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expired = (ACK_TIMEOUT != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Exactly one retire/pc_wr pulse per instruction, a sticky TRAP state for
// memory-ack timeouts, and a retired-instruction counter.
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes in
// DECODE; otherwise unknown opcodes retire in EXEC as a NOP.
// Handshake: mem_req is held high in FETCH/MEM until a cycle with mem_ack=1;
// that cycle completes the request. mem_ack is ignored in all other states.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int RET_CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic                 reg_wr,
    output logic                 alu_src,
    output logic                 mem_to_reg,
    output logic                 uncond_jump,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_src,
    output logic                 retire,
    output logic                 trap,
    output logic [RET_CNT_W-1:0] ret_cnt,
    output logic [2:0]           state_dbg
);

    state_t               state;
    state_t               state_next;
    logic                 trap_q;
    logic [RET_CNT_W-1:0] ret_q;
    logic                 waiting;
    logic                 expired;

    // A request is waiting when we are in a memory state and no ack arrived.
    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ack;

    ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting),
        .en      (waiting),
        .expired (expired)
    );

    // State register, sticky trap flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            trap_q <= 1'b0;
            ret_q  <= '0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP) trap_q <= 1'b1;
            if (retire) ret_q <= ret_q + RET_CNT_W'(1);
        end
    end

    // Next-state and output decode from state, opcode and mem_ack.
    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        reg_wr      = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        uncond_jump = 1'b0;
        alu_op      = ALU_ADD;
        pc_src      = PC_PLUS4;
        retire      = 1'b0;
        trap        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_wr      = 1'b1;
                    state_next = S_DECODE;
                end else if (expired) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (!is_known_op(opcode)) state_next = S_TRAP;
`endif
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op     = ALU_RFN;
                        state_next = S_WB;
                    end
                    OP_I: begin
                        alu_src    = 1'b1;
                        alu_op     = ALU_IFN;
                        state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src    = 1'b1;
                        state_next = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op     = ALU_SUB;
                        pc_wr      = 1'b1;
                        pc_src     = branch_taken ? PC_IMM : PC_PLUS4;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_src      = PC_IMM;
                        uncond_jump = 1'b1;
                        state_next  = S_WB;
                    end
                    OP_JALR: begin
                        pc_src      = PC_RS1;
                        alu_src     = 1'b1;
                        uncond_jump = 1'b1;
                        state_next  = S_WB;
                    end
                    default: begin
                        // Unknown opcode: retire as a NOP, no register write.
                        pc_wr      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_wr      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (expired) begin
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                reg_wr      = 1'b1;
                mem_to_reg  = (opcode == OP_LOAD);
                uncond_jump = (opcode == OP_JAL) || (opcode == OP_JALR);
                pc_wr       = 1'b1;
                pc_src      = (opcode == OP_JAL)  ? PC_IMM :
                              (opcode == OP_JALR) ? PC_RS1 : PC_PLUS4;
                retire      = 1'b1;
                state_next  = S_FETCH;
            end
            S_TRAP: begin
                trap       = trap_q;
                state_next = S_TRAP;
            end
            default: state_next = S_FETCH;
        endcase
        // Reset silences every output, abandoning any instruction in flight.
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            ir_wr       = 1'b0;
            pc_wr       = 1'b0;
            reg_wr      = 1'b0;
            alu_src     = 1'b0;
            mem_to_reg  = 1'b0;
            uncond_jump = 1'b0;
            alu_op      = ALU_ADD;
            pc_src      = PC_PLUS4;
            retire      = 1'b0;
            trap        = 1'b0;
        end
    end

    assign ret_cnt   = rst ? '0 : ret_q;
    assign state_dbg = rst ? 3'd0 : state;

endmodule
